kronos_mem_bridge: RTL and testbench
====================================

KRONOS_MEM_BRIDGE -- requirements
Module: kronos_mem_bridge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NumPorts, 2, core-side req/ack ports; legal range 1..8.
  AddrWidth, 20, memory address width.
  DataWidth, 32, data width; legal values 32 or 64.
  MemLatency, 1, fixed cycles from granted memory cycle to mem_rdata valid; legal range 1..4.
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
  clk_i  in  1  single clock; the block SHALL use only this clock.
  rst_ni  in  1  reset, asynchronous, active-low.
  port_req_i  in  NumPorts  per-port request, held high until ack.
  port_addr_i  in  NumPorts*32  per-port byte address.
  port_we_i  in  NumPorts  per-port write enable.
  port_wdata_i  in  NumPorts*DataWidth  per-port write data.
  port_mask_i  in  NumPorts*DataWidth/8  per-port byte mask.
  port_ack_o  out  NumPorts  per-port single-cycle completion pulse.
  port_rdata_o  out  NumPorts*DataWidth  per-port read data, valid with ack.
  mem_req_o  out  1  memory request.
  mem_gnt_i  in  1  memory grant.
  mem_addr_o  out  AddrWidth  memory address, equal to port_addr_i[AddrWidth-1:0] of the selected port.
  mem_we_o  out  1  memory write enable.
  mem_wdata_o  out  DataWidth  memory write data.
  mem_strb_o  out  DataWidth  bit strobe; each mask bit b replicated onto bits 8b+7..8b.
  mem_rdata_i  in  DataWidth  memory read data.

Function
REQ-003 A port SHALL be eligible when port_req_i=1 and its pending flag=0.
REQ-004 Arbitration SHALL be round-robin: search starts at rr_ptr and the first eligible port is selected.
REQ-005 mem_req_o SHALL be 1 when any port is eligible or lock=1; address, we, wdata and strb SHALL come from the selected port.
REQ-006 Handshake: a transfer occurs in a cycle with mem_req_o=1 and mem_gnt_i=1.
REQ-007 If mem_req_o=1 and mem_gnt_i=0, lock SHALL be set and the same port SHALL stay selected each cycle until granted, regardless of other requests.
REQ-008 rr_ptr SHALL advance to (granted port+1) mod NumPorts only on a transfer; lock SHALL clear on a transfer.
REQ-009 On a transfer, the granted port's pending flag SHALL set, and {valid, port id} SHALL enter a MemLatency-deep shift pipeline.
REQ-010 When the pipeline output is valid for port p: port_ack_o[p]=1 for exactly one cycle, port_rdata_o[p]=mem_rdata_i in that cycle, and pending[p] SHALL clear at the following clock edge.
REQ-011 Writes SHALL be acknowledged identically with the same latency; port_rdata_o content on a write ack is don't-care.
REQ-012 port_rdata_o[p] SHALL be zero whenever port_ack_o[p]=0.
REQ-013 Each port SHALL have at most one outstanding transaction; total outstanding transactions <= min(NumPorts, MemLatency).
REQ-014 A port whose ack is in the current cycle SHALL NOT be eligible in that cycle; it becomes eligible in the next cycle, giving a minimum per-port issue interval of MemLatency+1 cycles.
REQ-015 With different ports granted back-to-back, the bridge SHALL sustain one transfer per cycle.
REQ-016 Address bits 31..AddrWidth SHALL be ignored.
REQ-017 Deasserting port_req_i while a transaction is pending SHALL NOT cancel the ack.

Reset
REQ-018 While rst_ni=0: pipeline valid bits, pending flags, lock and rr_ptr SHALL be 0, and mem_req_o and all port_ack_o SHALL be 0.
REQ-019 Reset asserted mid-transaction SHALL discard it; no ack SHALL be emitted after reset release for a transaction granted before reset.

Verification
REQ-020 NumPorts=2, MemLatency=1, gnt tied 1; port0 read of 0x80000010 with mem_rdata=0xDEADBEEF -> mem_addr_o=0x00010 in cycle 0, port_ack_o[0]=1 with rdata 0xDEADBEEF in cycle 1, port 1 silent.
REQ-021 Both ports request continuously, gnt=1, rr_ptr=0 -> grants alternate 0,1,0,1 with no idle memory cycle.
REQ-022 port1 write, mask 4'b0101, gnt held 0 for 3 cycles -> mem_strb_o=0x00FF00FF held stable for 4 cycles while port0 is raised in between; grant goes to port1 first, then port0.
REQ-023 MemLatency=3, port0 requests continuously -> mem transfers at cycles 0 and 4, acks at cycles 3 and 7.
REQ-024 rst_ni pulled low 1 cycle after a grant with MemLatency=2 -> no port_ack_o pulse after release; first new request is granted to port 0.

Source files
------------

// File: rtl/kronos_mem_bridge.sv
// Multi-port to single-memory bridge: round-robin arbitration with grant lock,
// fixed-latency response pipeline and one outstanding transaction per port.
module kronos_mem_bridge #(
  parameter int unsigned NumPorts   = 2,
  parameter int unsigned AddrWidth  = 20,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MemLatency = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumPorts-1:0]             port_req_i,
  input  logic [NumPorts*32-1:0]          port_addr_i,
  input  logic [NumPorts-1:0]             port_we_i,
  input  logic [NumPorts*DataWidth-1:0]   port_wdata_i,
  input  logic [NumPorts*DataWidth/8-1:0] port_mask_i,
  output logic [NumPorts-1:0]             port_ack_o,
  output logic [NumPorts*DataWidth-1:0]   port_rdata_o,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [DataWidth-1:0]            mem_strb_o,
  input  logic [DataWidth-1:0]            mem_rdata_i
);

  localparam int unsigned IdW   = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned MaskW = DataWidth / 8;

  logic [NumPorts-1:0]   pending_q;
  logic [NumPorts-1:0]   eligible;
  logic [NumPorts-1:0]   set_pend;
  logic [IdW-1:0]        rr_ptr_q;
  logic [IdW-1:0]        lock_port_q;
  logic [IdW-1:0]        sel;
  logic                  lock_q;
  logic                  any_elig;
  logic                  xfer;
  logic [MemLatency-1:0] pipe_vld_q;
  logic [IdW-1:0]        pipe_id_q [MemLatency];

  // Upper address bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^port_addr_i;

  // A port whose ack is in flight or due now stays ineligible until pending clears.
  assign eligible = port_req_i & ~pending_q;

  // Round-robin search from rr_ptr; a stalled request keeps its port selected.
  always_comb begin
    sel      = rr_ptr_q;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < NumPorts; i++) begin
      for (int unsigned p = 0; p < NumPorts; p++) begin
        if (!any_elig && eligible[p] && ((32'(rr_ptr_q) + i) % NumPorts) == p) begin
          sel      = IdW'(p);
          any_elig = 1'b1;
        end
      end
    end
    if (lock_q) begin
      sel = lock_port_q;
    end
  end

  assign mem_req_o = rst_ni & (any_elig | lock_q);
  assign xfer      = mem_req_o & mem_gnt_i;

  // Request payload mux from the selected port.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    mem_strb_o  = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (sel == IdW'(p)) begin
        mem_addr_o  = port_addr_i[p*32 +: AddrWidth];
        mem_we_o    = port_we_i[p];
        mem_wdata_o = port_wdata_i[p*DataWidth +: DataWidth];
        for (int unsigned b = 0; b < MaskW; b++) begin
          mem_strb_o[b*8 +: 8] = {8{port_mask_i[p*MaskW + b]}};
        end
      end
    end
  end

  // Response decode at the pipeline tail; rdata is forced to zero off-ack.
  always_comb begin
    port_ack_o   = '0;
    port_rdata_o = '0;
    set_pend     = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (pipe_vld_q[MemLatency-1] && pipe_id_q[MemLatency-1] == IdW'(p)) begin
        port_ack_o[p]                          = 1'b1;
        port_rdata_o[p*DataWidth +: DataWidth] = mem_rdata_i;
      end
      if (xfer && sel == IdW'(p)) begin
        set_pend[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_port_q <= '0;
      pipe_vld_q  <= '0;
      for (int unsigned k = 0; k < MemLatency; k++) begin
        pipe_id_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= xfer;
      pipe_id_q[0]  <= sel;
      for (int unsigned k = 1; k < MemLatency; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        pipe_id_q[k]  <= pipe_id_q[k-1];
      end
      pending_q <= (pending_q & ~port_ack_o) | set_pend;
      if (xfer) begin
        rr_ptr_q <= IdW'((32'(sel) + 1) % NumPorts);
        lock_q   <= 1'b0;
      end else if (mem_req_o) begin
        lock_q      <= 1'b1;
        lock_port_q <= sel;
      end
    end
  end

endmodule

// File: tb/tb_kronos_mem_bridge.sv
// Bench for kronos_mem_bridge: three instances (MemLatency 1, 2, 3) checked
// every cycle against a transaction-level model, plus directed scenarios.
module tb_kronos_mem_bridge;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req    [3];
  logic [63:0] addr   [3];
  logic [1:0]  we     [3];
  logic [63:0] wdata  [3];
  logic [7:0]  mask   [3];
  logic        gnt    [3];
  logic [31:0] rdin   [3];
  logic [1:0]  ack    [3];
  logic [63:0] prdata [3];
  logic        mreq   [3];
  logic [19:0] maddr  [3];
  logic        mwe    [3];
  logic [31:0] mwdata [3];
  logic [31:0] mstrb  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    kronos_mem_bridge #(.NumPorts(2), .AddrWidth(20), .DataWidth(32), .MemLatency(g + 1)) u_dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .port_req_i   (req[g]),
      .port_addr_i  (addr[g]),
      .port_we_i    (we[g]),
      .port_wdata_i (wdata[g]),
      .port_mask_i  (mask[g]),
      .port_ack_o   (ack[g]),
      .port_rdata_o (prdata[g]),
      .mem_req_o    (mreq[g]),
      .mem_gnt_i    (gnt[g]),
      .mem_addr_o   (maddr[g]),
      .mem_we_o     (mwe[g]),
      .mem_wdata_o  (mwdata[g]),
      .mem_strb_o   (mstrb[g]),
      .mem_rdata_i  (rdin[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: per-port outstanding flag with its due cycle, arbiter pointer, lock.
  bit [1:0] m_pend [3];
  int       m_due  [3][2];
  int       m_rr   [3];
  bit       m_lock [3];
  int       m_lport[3];
  bit [1:0] e_ack  [3];
  int       e_sel  [3];
  bit       e_mreq [3];
  bit       e_xfer [3];

  task automatic chk(int m, string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s dut%0d cyc%0d observed=%0h expected=%0h", tag, m, cyc, obs, exp);
    end
  endtask

  task automatic model_clear(int m);
    m_pend[m] = '0; m_rr[m] = 0; m_lock[m] = 0; m_lport[m] = 0;
    m_due[m][0] = -1; m_due[m][1] = -1;
  endtask

  task automatic model_eval(int m);
    bit [1:0] elig;
    bit found;
    int p;
    e_ack[m] = '0;
    for (int q = 0; q < 2; q++)
      if (m_pend[m][q] && m_due[m][q] == cyc) e_ack[m][q] = 1'b1;
    elig  = req[m] & ~m_pend[m];
    found = 0;
    e_sel[m] = m_rr[m];
    for (int i = 0; i < 2; i++) begin
      p = (m_rr[m] + i) % 2;
      if (!found && elig[p]) begin e_sel[m] = p; found = 1; end
    end
    if (m_lock[m]) e_sel[m] = m_lport[m];
    e_mreq[m] = rst_n && (found || m_lock[m]);
    e_xfer[m] = e_mreq[m] && gnt[m];
    if (!rst_n) e_ack[m] = '0;
  endtask

  task automatic model_cmp(int m);
    int s;
    logic [31:0] es;
    chk(m, "mem_req", 64'(mreq[m]), 64'(e_mreq[m]));
    if (e_mreq[m]) begin
      s  = e_sel[m];
      es = '0;
      for (int b = 0; b < 4; b++)
        if (mask[m][4*s + b]) es = es | (32'hFF << (8*b));
      chk(m, "mem_addr", 64'(maddr[m]), (addr[m] >> (32*s)) & 64'h000F_FFFF);
      chk(m, "mem_we", 64'(mwe[m]), 64'(we[m][s]));
      chk(m, "mem_wdata", 64'(mwdata[m]), (wdata[m] >> (32*s)) & 64'hFFFF_FFFF);
      chk(m, "mem_strb", 64'(mstrb[m]), 64'(es));
    end
    chk(m, "port_ack", 64'(ack[m]), 64'(e_ack[m]));
    for (int p = 0; p < 2; p++)
      chk(m, "port_rdata", (prdata[m] >> (32*p)) & 64'hFFFF_FFFF,
          e_ack[m][p] ? 64'(rdin[m]) : 64'h0);
  endtask

  task automatic model_update(int m);
    if (!rst_n) begin model_clear(m); return; end
    for (int p = 0; p < 2; p++)
      if (e_ack[m][p]) m_pend[m][p] = 1'b0;
    if (e_xfer[m]) begin
      m_pend[m][e_sel[m]] = 1'b1;
      m_due[m][e_sel[m]]  = cyc + m + 1;
      m_rr[m]   = (e_sel[m] + 1) % 2;
      m_lock[m] = 0;
    end else if (e_mreq[m]) begin
      m_lock[m]  = 1;
      m_lport[m] = e_sel[m];
    end
  endtask

  task automatic sample();
    @(negedge clk);
    for (int m = 0; m < 3; m++) begin model_eval(m); model_cmp(m); end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int m = 0; m < 3; m++) model_update(m);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 3; m++) begin
      req[m] = '0; addr[m] = '0; we[m] = '0; wdata[m] = '0;
      mask[m] = '0; gnt[m] = 1'b1; rdin[m] = $urandom;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample(); advance();
    sample(); advance();
    idle_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    for (int m = 0; m < 3; m++) begin model_clear(m); req[m] = 2'b11; end

    // Reset holds mem_req and acks low even with requests pending.
    sample();
    for (int m = 0; m < 3; m++) begin
      chk(m, "rst_mem_req", 64'(mreq[m]), 64'h0);
      chk(m, "rst_ack", 64'(ack[m]), 64'h0);
    end
    advance();
    do_reset();

    // Single read, upper address bits dropped, ack one cycle later.
    addr[0] = {32'h0, 32'h8000_0010};
    req[0]  = 2'b01;
    rdin[0] = 32'hDEAD_BEEF;
    sample();
    chk(0, "rd_addr", 64'(maddr[0]), 64'h10);
    chk(0, "rd_req", 64'(mreq[0]), 64'h1);
    advance();
    sample();
    chk(0, "rd_ack", 64'(ack[0]), 64'h1);
    chk(0, "rd_data", prdata[0], 64'h0000_0000_DEAD_BEEF);
    advance();
    req[0] = 2'b00;
    sample(); chk(0, "rd_quiet", 64'(ack[0]), 64'h0); advance();

    // Both ports continuous: grants alternate with no idle cycle.
    do_reset();
    addr[0] = {32'h0000_0200, 32'h0000_0100};
    req[0]  = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rdin[0] = $urandom;
      sample();
      chk(0, "alt_req", 64'(mreq[0]), 64'h1);
      chk(0, "alt_port", 64'(maddr[0]), (i % 2 == 1) ? 64'h200 : 64'h100);
      advance();
    end
    req[0] = 2'b00;
    for (int i = 0; i < 3; i++) begin sample(); advance(); end

    // Stalled write on port1 stays locked while port0 joins.
    do_reset();
    addr[0]  = {32'h0000_0300, 32'h0000_0100};
    we[0]    = 2'b10;
    mask[0]  = 8'h5F;
    wdata[0] = {32'hCAFE_F00D, 32'h1234_5678};
    req[0]   = 2'b10;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) req[0] = 2'b11;
      gnt[0] = (i == 3);
      sample();
      chk(0, "lock_strb", 64'(mstrb[0]), 64'h00FF_00FF);
      chk(0, "lock_addr", 64'(maddr[0]), 64'h300);
      chk(0, "lock_req", 64'(mreq[0]), 64'h1);
      advance();
    end
    sample();
    chk(0, "lock_next", 64'(maddr[0]), 64'h100);
    chk(0, "lock_ack1", 64'(ack[0]), 64'h2);
    advance();
    req[0] = 2'b01;
    sample(); chk(0, "lock_ack0", 64'(ack[0]), 64'h1); advance();
    req[0] = 2'b00;
    for (int i = 0; i < 2; i++) begin sample(); advance(); end

    // Latency 3, one port continuous: transfers at 0 and 4, acks at 3 and 7.
    do_reset();
    addr[2] = {32'h0, 32'h0000_0040};
    req[2]  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      rdin[2] = $urandom;
      sample();
      chk(2, "l3_xfer", 64'(mreq[2] & gnt[2]), (i == 0 || i == 4) ? 64'h1 : 64'h0);
      chk(2, "l3_ack", 64'(ack[2]), (i == 3 || i == 7) ? 64'h1 : 64'h0);
      advance();
    end
    req[2] = 2'b00;
    for (int i = 0; i < 4; i++) begin sample(); advance(); end

    // Reset one cycle after a latency-2 grant discards the transaction.
    do_reset();
    addr[1] = {32'h0000_0020, 32'h0000_0010};
    req[1]  = 2'b01;
    sample(); chk(1, "rst_grant", 64'(mreq[1]), 64'h1); advance();
    rst_n  = 1'b0;
    req[1] = 2'b00;
    sample(); advance();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(); chk(1, "rst_noack", 64'(ack[1]), 64'h0); advance();
    end
    req[1] = 2'b11;
    sample(); chk(1, "rst_first", 64'(maddr[1]), 64'h10); advance();
    for (int i = 0; i < 3; i++) begin sample(); advance(); end
    req[1] = 2'b00;
    for (int i = 0; i < 4; i++) begin sample(); advance(); end

    // Randomized traffic on all three instances.
    do_reset();
    for (int t = 0; t < 400; t++) begin
      for (int m = 0; m < 3; m++) begin
        gnt[m]  = ($urandom % 4) != 0;
        rdin[m] = $urandom;
      end
      sample();
      advance();
      for (int m = 0; m < 3; m++) begin
        for (int p = 0; p < 2; p++) begin
          if (!req[m][p]) begin
            if ($urandom % 3 == 0) begin
              req[m][p]            = 1'b1;
              addr[m][p*32 +: 32]  = $urandom;
              wdata[m][p*32 +: 32] = $urandom;
              we[m][p]             = 1'($urandom);
              mask[m][p*4 +: 4]    = 4'($urandom);
            end
          end else if (e_ack[m][p]) begin
            if ($urandom % 2 == 0) req[m][p] = 1'b0;
          end else if (m_pend[m][p] && ($urandom % 4 == 0)) begin
            req[m][p] = 1'b0;
          end
        end
      end
    end
    idle_inputs();
    for (int i = 0; i < 6; i++) begin sample(); advance(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
